// File: rtl/aim65_kbd_matrix.sv
// aim65_kbd_matrix: PS/2 keyboard front end emulating the AIM-65 8x8 key
// matrix as seen through the RIOT port pins.
//
// Optional build macro: KBD_PARITY_CHECK_EN (when defined, odd-parity
// mismatches are rejected as frame errors; otherwise parity is ignored).
//
// Ports:
//   clk       system clock (same as RIOT clk)
//   reset     synchronous, active-high reset
//   ps2_clk   raw PS/2 clock (asynchronous)
//   ps2_data  raw PS/2 data (asynchronous)
//   scan_col  column select from RIOT paOut, active-low
//   row_out   row return to RIOT pbIn, active-low, registered
//   key_valid one-cycle pulse when key_code updates
//   key_code  last complete scancode byte received
//   frame_err one-cycle pulse on parity, stop-bit or timeout error
module aim65_kbd_matrix #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] scan_col,
  output logic [7:0] row_out,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic [1:0]      r_clk_sync, r_data_sync;
  logic            r_clk_filt, r_data_filt, r_clk_filt_d;
  logic [FW-1:0]   r_clk_fcnt, r_data_fcnt;
  state_t          r_state;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic            r_parity;
  logic [TW-1:0]   r_to_cnt;
  logic            r_brk, r_ext;
  logic [7:0][7:0] r_matrix;

  logic            w_fall;
  logic            w_par_odd;
  logic            w_par_ignore;
  logic            w_stop_ok;
  logic            w_hit;
  logic [2:0]      w_row, w_col;

  // Two-flop synchronizers; idle PS/2 lines are high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
    end
  end

  // Level changes only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_filt   <= 1'b1;
      r_data_filt  <= 1'b1;
      r_clk_filt_d <= 1'b1;
      r_clk_fcnt   <= '0;
      r_data_fcnt  <= '0;
    end else begin
      r_clk_filt_d <= r_clk_filt;
      if (r_clk_sync[1] == r_clk_filt) begin
        r_clk_fcnt <= '0;
      end else if (r_clk_fcnt == FW'(FILTER_LEN - 1)) begin
        r_clk_filt <= r_clk_sync[1];
        r_clk_fcnt <= '0;
      end else begin
        r_clk_fcnt <= r_clk_fcnt + FW'(1);
      end
      if (r_data_sync[1] == r_data_filt) begin
        r_data_fcnt <= '0;
      end else if (r_data_fcnt == FW'(FILTER_LEN - 1)) begin
        r_data_filt <= r_data_sync[1];
        r_data_fcnt <= '0;
      end else begin
        r_data_fcnt <= r_data_fcnt + FW'(1);
      end
    end
  end

  assign w_fall    = r_clk_filt_d & ~r_clk_filt;
  assign w_par_odd = ^{r_shift, r_parity};

`ifdef KBD_PARITY_CHECK_EN
  assign w_par_ignore = 1'b0;
`else
  assign w_par_ignore = 1'b1;
`endif

  assign w_stop_ok = r_data_filt & (w_par_odd | w_par_ignore);

  // Receive FSM with per-frame timeout; emits key_valid/frame_err pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_to_cnt  <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      frame_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_to_cnt <= '0;
        if (w_fall && !r_data_filt) begin
          r_state  <= ST_DATA;
          r_bitcnt <= '0;
        end
      end else if (w_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          ST_DATA: begin
            r_shift  <= {r_data_filt, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) r_state <= ST_PARITY;
          end
          ST_PARITY: begin
            r_parity <= r_data_filt;
            r_state  <= ST_STOP;
          end
          default: begin
            r_state <= ST_IDLE;
            if (w_stop_ok) begin
              key_valid <= 1'b1;
              key_code  <= r_shift;
            end else begin
              frame_err <= 1'b1;
            end
          end
        endcase
      end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        r_state   <= ST_IDLE;
        r_to_cnt  <= '0;
        frame_err <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end
    end
  end

  // Scancode map: {ext, code} -> {hit, row, col}.
  always_comb begin
    w_hit = 1'b0;
    w_row = 3'd0;
    w_col = 3'd0;
    case ({r_ext, key_code})
      9'h01C: begin w_hit = 1'b1; w_row = 3'd2; w_col = 3'd1; end
      9'h01B: begin w_hit = 1'b1; w_row = 3'd2; w_col = 3'd2; end
      9'h175: begin w_hit = 1'b1; w_row = 3'd7; w_col = 3'd0; end
      default: ;
    endcase
  end

  // Make/break decoder; acts on the cycle after key_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_brk    <= 1'b0;
      r_ext    <= 1'b0;
      r_matrix <= '0;
    end else if (key_valid) begin
      if (key_code == 8'hF0) begin
        r_brk <= 1'b1;
      end else if (key_code == 8'hE0) begin
        r_ext <= 1'b1;
      end else if ((key_code == 8'hAA || key_code == 8'hFA || key_code == 8'hEE)
                   && !r_brk && !r_ext) begin
        // keyboard status replies outside a sequence carry no key
      end else begin
        if (w_hit) r_matrix[w_row][w_col] <= ~r_brk;
        r_brk <= 1'b0;
        r_ext <= 1'b0;
      end
    end
  end

  // Row returns: a row goes low when any selected column has a pressed key.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_out <= 8'hFF;
    end else begin
      for (int r = 0; r < 8; r++) begin
        row_out[r] <= ~|(r_matrix[r] & ~scan_col);
      end
    end
  end

endmodule

// File: tb/tb_aim65_kbd_matrix.sv
module tb_aim65_kbd_matrix;

  localparam int unsigned TO = 2000;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_col;
  logic [7:0] row_out;
  logic       key_valid;
  logic [7:0] key_code;
  logic       frame_err;

  int         n_vec = 0;
  int         n_err = 0;
  int         ferr_seen = 0;
  int         ferr_exp = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  aim65_kbd_matrix #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .scan_col(scan_col), .row_out(row_out), .key_valid(key_valid),
    .key_code(key_code), .frame_err(frame_err)
  );

  // Scoreboard: every key_valid pulse must match the oldest expected byte.
  always @(negedge clk) begin
    logic [7:0] e;
    if (key_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL key_valid_unexpected: got code %02h, required no pulse", key_code);
      end else begin
        e = exp_q.pop_front();
        if (key_code !== e) begin
          n_err++;
          $display("FAIL key_code: got %02h, required %02h", key_code, e);
        end
      end
    end
    if (frame_err === 1'b1) ferr_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(12);
    ps2_clk = 1'b0;
    tick(25);
    ps2_clk = 1'b1;
    tick(13);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(bad_par ? ^d : ~^d);
    send_bit(1'b1);
    tick(40);
  endtask

  task automatic set_scan(input logic [7:0] s);
    scan_col = s;
    tick(3);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    scan_col = 8'h00;
    tick(1);
    n_vec++;
    if (row_out !== 8'hFF) begin n_err++; $display("FAIL reset_row_out: got %02h, required ff", row_out); end
    n_vec++;
    if (key_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_err++; $display("FAIL reset_pulses: got kv=%b fe=%b, required 0 0", key_valid, frame_err);
    end
    reset = 1'b0;
    tick(20);
    n_vec++;
    if (row_out !== 8'hFF) begin n_err++; $display("FAIL post_reset_row_out: got %02h, required ff", row_out); end
  endtask

  task automatic test_make;
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0);
    set_scan(8'hFD);
    n_vec++;
    if (row_out !== 8'hFB) begin n_err++; $display("FAIL make_row_out: got %02h, required fb", row_out); end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL make_kv_missing: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_break;
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h1C);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    set_scan(8'hFD);
    n_vec++;
    if (row_out !== 8'hFF) begin n_err++; $display("FAIL break_row_out: got %02h, required ff", row_out); end
    set_scan(8'h00);
    n_vec++;
    if (row_out !== 8'hFF) begin n_err++; $display("FAIL break_all_cols: got %02h, required ff", row_out); end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL break_kv_missing: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] seq [4] = '{8'h1C, 8'h1B, 8'hE0, 8'h75};
    logic [7:0] rel [3] = '{8'hE0, 8'hF0, 8'h75};
    foreach (seq[i]) begin exp_q.push_back(seq[i]); send_frame(seq[i], 1'b0); end
    set_scan(8'h00);
    n_vec++;
    if (row_out !== 8'h7B) begin n_err++; $display("FAIL multi_row_out: got %02h, required 7b", row_out); end
    foreach (rel[i]) begin exp_q.push_back(rel[i]); send_frame(rel[i], 1'b0); end
    set_scan(8'h00);
    n_vec++;
    if (row_out !== 8'hFB) begin n_err++; $display("FAIL ext_release_row_out: got %02h, required fb", row_out); end
    set_scan(8'hFE);
    n_vec++;
    if (row_out !== 8'hFF) begin n_err++; $display("FAIL col0_row_out: got %02h, required ff", row_out); end
  endtask

  task automatic test_parity;
`ifdef KBD_PARITY_CHECK_EN
    ferr_exp++;
`else
    exp_q.push_back(8'h1C);
`endif
    send_frame(8'h1C, 1'b1);
    n_vec++;
    if (ferr_seen != ferr_exp) begin n_err++; $display("FAIL parity_frame_err: got %0d, required %0d", ferr_seen, ferr_exp); end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL parity_kv_missing: got %0d pending, required 0", exp_q.size()); end
    set_scan(8'h00);
    n_vec++;
    if (row_out !== 8'hFB) begin n_err++; $display("FAIL parity_row_out: got %02h, required fb", row_out); end
  endtask

  task automatic test_timeout_glitch;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_data = 1'b1;
    tick(TO + 100);
    ferr_exp++;
    n_vec++;
    if (ferr_seen != ferr_exp) begin n_err++; $display("FAIL timeout_frame_err: got %0d, required %0d", ferr_seen, ferr_exp); end
    ps2_data = 1'b0;
    repeat (3) begin
      ps2_clk = 1'b0;
      tick(4);
      ps2_clk = 1'b1;
      tick(20);
    end
    ps2_data = 1'b1;
    tick(20);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h1B);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1B, 1'b0);
    n_vec++;
    if (ferr_seen != ferr_exp) begin n_err++; $display("FAIL glitch_frame_err: got %0d, required %0d", ferr_seen, ferr_exp); end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL glitch_kv_missing: got %0d pending, required 0", exp_q.size()); end
    set_scan(8'hFB);
    n_vec++;
    if (row_out !== 8'hFF) begin n_err++; $display("FAIL released_1b_row_out: got %02h, required ff", row_out); end
    set_scan(8'hFD);
    n_vec++;
    if (row_out !== 8'hFB) begin n_err++; $display("FAIL held_1c_row_out: got %02h, required fb", row_out); end
  endtask

  task automatic test_reset_midframe;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b1;
    ps2_data = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(20);
    set_scan(8'h00);
    n_vec++;
    if (row_out !== 8'hFF) begin n_err++; $display("FAIL midreset_row_out: got %02h, required ff", row_out); end
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h1C);
    send_frame(8'hAA, 1'b0);
    send_frame(8'h1C, 1'b0);
    set_scan(8'h00);
    n_vec++;
    if (row_out !== 8'hFB) begin n_err++; $display("FAIL after_reset_make: got %02h, required fb", row_out); end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL after_reset_kv_missing: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    scan_col = 8'hFF;
    tick(3);
    test_reset();
    test_make();
    test_break();
    test_back_to_back();
    test_parity();
    test_timeout_glitch();
    test_reset_midframe();
    n_vec++;
    if (ferr_seen != ferr_exp) begin n_err++; $display("FAIL final_frame_err: got %0d, required %0d", ferr_seen, ferr_exp); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
